// File: rtl/conv_layer_seq_pkg.sv
// -----------------------------------------------------------------------------
// conv_layer_seq_pkg
//   Shared definitions for the layer sequencer and the ConvUnit decode logic:
//   the 3-bit phase encoding broadcast on current_state, the default layer
//   counter width and the default per-phase watchdog limits.
// -----------------------------------------------------------------------------
package conv_layer_seq_pkg;

  // Phase encoding seen by every ConvUnit. Values are fixed; ConvUnits decode
  // these numbers directly, so do not reorder.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CONV   = 3'd3,
    ST_POOL   = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } conv_state_e;

  localparam int              LAYER_W_DEF     = 4;
  localparam int              TIMEOUT_W_DEF   = 20;
  localparam logic [19:0]     TIMEOUT_CYC_DEF = 20'hFFFFF;

  // True for the phases in which a ConvUnit is working and may signal
  // completion with state_rst.
  function automatic logic is_phase(input conv_state_e s);
    return (s == ST_LOAD_W) || (s == ST_LOAD_B) ||
           (s == ST_CONV)   || (s == ST_POOL);
  endfunction

endpackage

// File: rtl/conv_phase_wdog.sv
// -----------------------------------------------------------------------------
// conv_phase_wdog
//   Per-phase watchdog for the layer sequencer. Counts the cycles spent in an
//   active phase and flags expiry when the phase has lasted TIMEOUT_CYC cycles.
//   Also provides the "first cycle of a phase" flag used to drop stale
//   state_rst pulses that belong to the previous phase.
//
// Ports
//   clk      in  system clock
//   rstn     in  asynchronous active-low reset
//   clr      in  high during the first cycle after any state entry
//   en       in  current state is an active phase (LOAD_W..POOL)
//   expired  out phase has reached TIMEOUT_CYC cycles (combinational on regs)
//   first    out first cycle of an active phase
// -----------------------------------------------------------------------------
module conv_phase_wdog #(
  parameter int                   TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = '1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired,
  output logic first
);

  localparam logic [TIMEOUT_W-1:0] LP_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] LP_LAST = TIMEOUT_CYC - LP_ONE;

  // r_cnt holds the number of completed cycles in the current phase. During
  // the entry cycle it still holds the previous phase's count, so it is
  // ignored there and restarted at 1 (the entry cycle itself).
  logic [TIMEOUT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= en ? LP_ONE : '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + LP_ONE;
    end
  end

  // Cycle k (k >= 2) of a phase sees r_cnt == k-1, so expiry fires in cycle
  // TIMEOUT_CYC and the sequencer leaves the phase at the end of that cycle.
  assign expired = en && !clr && (r_cnt == LP_LAST);
  assign first   = en && clr;

endmodule

// File: rtl/conv_layer_seq.sv
// -----------------------------------------------------------------------------
// conv_layer_seq
//   Layer sequencer for the ConvUnit array. Walks each layer through weight
//   load, bias load, convolution and optional pooling, advancing a phase on
//   each ConvUnit state_rst ("phase complete") pulse, for num_layers+1 layers.
//
// Ports
//   clk            in   system clock
//   rstn           in   asynchronous active-low reset
//   start          in   1-cycle pulse, accepted in IDLE or ERROR
//   abort          in   level, returns to IDLE next cycle from any state
//   num_layers     in   layer count minus 1, sampled on accepted start
//   pool_en        in   pooling enable for the layer at layer_idx
//   state_rst      in   ConvUnit phase-done pulse
//   current_state  out  registered phase encoding (conv_state_e values)
//   layer_idx      out  layer currently processed
//   busy           out  high in LOAD_W..NEXT
//   done           out  1-cycle pulse while in DONE
//   err            out  sticky while in ERROR
// -----------------------------------------------------------------------------
module conv_layer_seq
  import conv_layer_seq_pkg::*;
#(
  parameter int                   LAYER_W     = LAYER_W_DEF,
  parameter int                   TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(TIMEOUT_CYC_DEF)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic               pool_en,
  input  logic               state_rst,
  output logic [2:0]         current_state,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [LAYER_W-1:0] LP_LAYER_ONE = LAYER_W'(1);

  conv_state_e        r_state;
  logic [LAYER_W-1:0] r_layer;
  logic [LAYER_W-1:0] r_num;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_entry;   // first cycle after a state change

  logic               w_phase;
  logic               w_expired;
  logic               w_first;
  logic               w_adv;

  assign w_phase = is_phase(r_state);

  conv_phase_wdog #(
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (r_entry),
    .en      (w_phase),
    .expired (w_expired),
    .first   (w_first)
  );

  // In the entry cycle the ConvUnit is still reacting to the old state, so a
  // pulse seen then is stale and is dropped outright.
  assign w_adv = state_rst && !w_first;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_layer <= '0;
      r_num   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_entry <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_entry <= 1'b0;

      if (abort) begin
        // Abort outranks start, phase completion and the watchdog.
        r_state <= ST_IDLE;
        r_layer <= '0;
        r_busy  <= 1'b0;
        r_err   <= 1'b0;
        r_entry <= (r_state != ST_IDLE);
      end else begin
        unique case (r_state)
          ST_IDLE, ST_ERROR: begin
            // A start from ERROR clears err and behaves as a fresh start.
            if (start) begin
              r_num   <= num_layers;
              r_layer <= '0;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_LOAD_W;
              r_entry <= 1'b1;
            end
          end

          ST_LOAD_W, ST_LOAD_B, ST_CONV, ST_POOL: begin
            if (w_expired) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_entry <= 1'b1;
            end else if (w_adv) begin
              r_entry <= 1'b1;
              unique case (r_state)
                ST_LOAD_W: r_state <= ST_LOAD_B;
                ST_LOAD_B: r_state <= ST_CONV;
                ST_CONV:   r_state <= pool_en ? ST_POOL : ST_NEXT;
                default:   r_state <= ST_NEXT;
              endcase
            end
          end

          ST_NEXT: begin
            r_entry <= 1'b1;
            // Compare before incrementing so layer_idx never wraps, even when
            // num_layers is the all-ones maximum.
            if (r_layer == r_num) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_layer <= r_layer + LP_LAYER_ONE;
              r_state <= ST_LOAD_W;
            end
          end

          ST_DONE: begin
            r_state <= ST_IDLE;
            r_entry <= 1'b1;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign current_state = r_state;
  assign layer_idx     = r_layer;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_conv_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_seq
//   Scoreboard bench for conv_layer_seq. The stimulus thread pushes the
//   expected sequence of state visits (state, layer, busy, done, err and how
//   long the previous state lasted); a monitor pops and compares each time
//   current_state changes. A small ConvUnit model generates state_rst.
// -----------------------------------------------------------------------------
module tb_conv_layer_seq;
  import conv_layer_seq_pkg::*;

  localparam int          LW = 4;
  localparam int          TW = 20;
  localparam logic [19:0] TO = 20'd16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] num_layers = '0;
  logic          pool_en;
  logic          state_rst;
  logic [2:0]    current_state;
  logic [LW-1:0] layer_idx;
  logic          busy;
  logic          done;
  logic          err;

  // ConvUnit model controls
  logic          m_rst = 1'b0;
  logic          force_rst = 1'b0;
  logic [15:0]   pool_cfg = '1;
  int            m_mode = 0;     // 0 off, 1 pulse in every phase, 2 held high, 3 LOAD_W only
  int            m_n = 5;        // pulse in cycle m_n of a phase
  int            m_cnt = 0;
  logic [2:0]    m_last = 3'd0;

  assign state_rst = m_rst | force_rst;
  assign pool_en   = pool_cfg[layer_idx];

  always #5 clk = ~clk;

  conv_layer_seq #(
    .LAYER_W     (LW),
    .TIMEOUT_W   (TW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .abort         (abort),
    .num_layers    (num_layers),
    .pool_en       (pool_en),
    .state_rst     (state_rst),
    .current_state (current_state),
    .layer_idx     (layer_idx),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [LW-1:0] layer;
    logic          b;
    logic          d;
    logic          e;
    logic [7:0]    prev;   // expected length of the previous state, 0 = don't care
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [2:0] st, input int layer, input logic b,
                               input logic d, input logic e, input int prev);
    exp_t x;
    x.st    = st;
    x.layer = layer[LW-1:0];
    x.b     = b;
    x.d     = d;
    x.e     = e;
    x.prev  = prev[7:0];
    q.push_back(x);
  endfunction

  // One layer: LOAD_W, LOAD_B, CONV, [POOL], NEXT, each phase lasting dw cycles.
  function automatic void push_layer(input int l, input bit pool, input int dw, input int first_prev);
    push(ST_LOAD_W, l, 1'b1, 1'b0, 1'b0, first_prev);
    push(ST_LOAD_B, l, 1'b1, 1'b0, 1'b0, dw);
    push(ST_CONV,   l, 1'b1, 1'b0, 1'b0, dw);
    if (pool) push(ST_POOL, l, 1'b1, 1'b0, 1'b0, dw);
    push(ST_NEXT,   l, 1'b1, 1'b0, 1'b0, dw);
  endfunction

  function automatic void push_end(input int l);
    push(ST_DONE, l, 1'b0, 1'b1, 1'b0, 1);
    push(ST_IDLE, l, 1'b0, 1'b0, 1'b0, 1);
  endfunction

  // ConvUnit model: counts cycles since the last state change seen at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (current_state !== m_last) begin
        m_last = current_state;
        m_cnt  = 1;
      end else begin
        m_cnt++;
      end
      case (m_mode)
        1:       m_rst = (current_state inside {3'd1, 3'd2, 3'd3, 3'd4}) && (m_cnt == m_n);
        2:       m_rst = 1'b1;
        3:       m_rst = (current_state == 3'd1) && (m_cnt == m_n);
        default: m_rst = 1'b0;
      endcase
    end
  end

  // Monitor: one scoreboard entry per observed state change.
  int         mon_cyc = 0;
  int         last_chg = 0;
  logic [2:0] mon_last = 3'd0;

  initial begin
    @(posedge rstn);
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (done === 1'b1) done_cnt++;
      if (current_state !== mon_last) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_state: got %0d after %0d with empty scoreboard", current_state, mon_last);
        end else begin
          exp_t x;
          x = q.pop_front();
          check("state", 32'(current_state), 32'(x.st));
          check("layer_idx", 32'(layer_idx), 32'(x.layer));
          check("busy", 32'(busy), 32'(x.b));
          check("done", 32'(done), 32'(x.d));
          check("err", 32'(err), 32'(x.e));
          if (x.prev != 0) check("prev_dwell", 32'(mon_cyc - last_chg), 32'(x.prev));
        end
        mon_last = current_state;
        last_chg = mon_cyc;
      end
    end
  end

  task automatic pulse_start(input int nl);
    @(negedge clk);
    num_layers = nl[LW-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check(name, 32'(q.size()), 32'd0);
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int layer, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(current_state == st && layer_idx == layer[LW-1:0]) && k < budget);
    check(name, 32'(k < budget), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(current_state), 32'd0);
    check({tag, "_layer"}, 32'(layer_idx), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int d0;

  initial begin
    #2 rstn = 1'b0;
    #20;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two layers with pooling, phase done 5 cycles after each entry.
    m_mode = 1; m_n = 5; pool_cfg = '1;
    push_layer(0, 1, 5, 0);
    push_layer(1, 1, 5, 1);
    push_end(1);
    d0 = done_cnt;
    pulse_start(1);
    drain("t1_drain", 100);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // 2: layer 0 skips POOL, layer 1 pools.
    pool_cfg = 16'h0002;
    push_layer(0, 0, 5, 0);
    push_layer(1, 1, 5, 1);
    push_end(1);
    d0 = done_cnt;
    pulse_start(1);
    drain("t2_drain", 100);
    check("t2_done_count", 32'(done_cnt - d0), 32'd1);

    // 3: state_rst held high; every phase lasts exactly 2 cycles.
    pool_cfg = '1;
    m_mode = 2;
    push_layer(0, 1, 2, 0);
    push_end(0);
    d0 = done_cnt;
    pulse_start(0);
    drain("t3_drain", 40);
    check("t3_done_count", 32'(done_cnt - d0), 32'd1);
    m_mode = 0;
    repeat (2) @(negedge clk);

    // 4: abort in CONV of layer 2 together with state_rst.
    m_mode = 1; m_n = 3;
    push_layer(0, 1, 3, 0);
    push_layer(1, 1, 3, 1);
    push(ST_LOAD_W, 2, 1'b1, 1'b0, 1'b0, 1);
    push(ST_LOAD_B, 2, 1'b1, 1'b0, 1'b0, 3);
    push(ST_CONV,   2, 1'b1, 1'b0, 1'b0, 3);
    push(ST_IDLE,   0, 1'b0, 1'b0, 1'b0, 2);
    d0 = done_cnt;
    pulse_start(3);
    wait_state("t4_reach_conv_l2", ST_CONV, 2, 200);
    @(negedge clk);
    abort = 1'b1;
    force_rst = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    force_rst = 1'b0;
    check("t4_state", 32'(current_state), 32'd0);
    check("t4_layer", 32'(layer_idx), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    drain("t4_drain", 20);
    repeat (5) @(negedge clk);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // 5: LOAD_B never completes -> ERROR after 16 cycles, then restart.
    m_mode = 3; m_n = 3;
    push(ST_LOAD_W, 0, 1'b1, 1'b0, 1'b0, 0);
    push(ST_LOAD_B, 0, 1'b1, 1'b0, 1'b0, 3);
    push(ST_ERROR,  0, 1'b0, 1'b0, 1'b1, 16);
    pulse_start(0);
    drain("t5_drain_err", 60);
    repeat (4) @(negedge clk);
    check("t5_err", 32'(err), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    m_mode = 0;
    push(ST_LOAD_W, 0, 1'b1, 1'b0, 1'b0, 0);
    pulse_start(0);
    drain("t5_drain_restart", 10);
    check("t5_err_cleared", 32'(err), 32'd0);
    push(ST_IDLE, 0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("t5_drain_abort", 10);

    // 6: async reset mid-POOL, then a clean run of layer 0.
    m_mode = 1; m_n = 3;
    push(ST_LOAD_W, 0, 1'b1, 1'b0, 1'b0, 0);
    push(ST_LOAD_B, 0, 1'b1, 1'b0, 1'b0, 3);
    push(ST_CONV,   0, 1'b1, 1'b0, 1'b0, 3);
    push(ST_POOL,   0, 1'b1, 1'b0, 1'b0, 3);
    push(ST_IDLE,   0, 1'b0, 1'b0, 1'b0, 0);
    pulse_start(0);
    wait_state("t6_reach_pool", ST_POOL, 0, 100);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drain("t6_drain_reset", 10);
    push_layer(0, 1, 3, 0);
    push_end(0);
    d0 = done_cnt;
    pulse_start(0);
    drain("t6_drain_run", 60);
    check("t6_done_count", 32'(done_cnt - d0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
